// File: rtl/signed_accum_sat.sv
// signed_accum_sat: registered signed ADD/SUB/ACC/CLR stage with a valid/ready
// handshake on both sides, overflow flagging and a saturating sample counter.
// There is a single output register and no skid buffer: in_ready falls while
// a result is stalled at the output.
//
// Build option: define SIGNED_ACCUM_SATURATE_EN to clamp overflowing results
// to the signed ACC_W range. Without it, results wrap to the low ACC_W bits.
// Ports and timing are the same in both builds.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | output register holds no valid result
// ST_FULL  | output register holds a result awaiting transfer

module signed_accum_sat #(
    parameter int N     = 8,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    state_t r_state;
    state_t w_state_next;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_result;
    logic             r_ovf;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    logic                    w_in_xfer;
    logic signed [ACC_W:0]   w_a_ext;
    logic signed [ACC_W:0]   w_b_ext;
    logic signed [ACC_W:0]   w_acc_ext;
    logic signed [ACC_W:0]   w_exact;
    logic                    w_ovf;
    logic [ACC_W-1:0]        w_store;

    assign out_valid  = (r_state == ST_FULL);
    assign in_ready   = !out_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign result     = r_result;
    assign ovf        = r_ovf;
    assign ovf_sticky = r_sticky;
    assign count      = r_count;

    // One extra bit of headroom holds every exact sum/difference of the operands.
    assign w_a_ext   = {{(ACC_W + 1 - N){a[N-1]}}, a};
    assign w_b_ext   = {{(ACC_W + 1 - N){b[N-1]}}, b};
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};

    // Exact result of the selected operation at ACC_W+1 bits.
    always_comb begin
        w_exact = w_a_ext + w_b_ext;
        case (op)
            OP_ADD:  w_exact = w_a_ext + w_b_ext;
            OP_SUB:  w_exact = w_a_ext - w_b_ext;
            OP_ACC:  w_exact = w_acc_ext + w_a_ext;
            OP_CLR:  w_exact = w_a_ext;
            default: w_exact = w_a_ext + w_b_ext;
        endcase
    end

    // Out of range exactly when the two top bits of the exact value disagree.
    assign w_ovf = w_exact[ACC_W] ^ w_exact[ACC_W-1];

    // Value that is stored into the result register and, for ACC/CLR, the accumulator.
    always_comb begin
        w_store = w_exact[ACC_W-1:0];
`ifdef SIGNED_ACCUM_SATURATE_EN
        if (w_ovf) begin
            w_store = w_exact[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                     : {1'b0, {(ACC_W - 1){1'b1}}};
        end
`endif
    end

    // Output-valid state: fill on input transfer, drain on output-only transfer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_in_xfer) w_state_next = ST_FULL;
            ST_FULL:  if (out_ready && !w_in_xfer) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // State, result, accumulator, counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state  <= ST_EMPTY;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_in_xfer) begin
                r_result <= w_store;
                r_ovf    <= w_ovf;
                case (op)
                    OP_ACC: begin
                        r_acc    <= w_store;
                        r_sticky <= r_sticky | w_ovf;
                        if (r_count != {CNT_W{1'b1}}) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    OP_CLR: begin
                        // A load cannot overflow, so the sticky flag simply restarts.
                        r_acc    <= w_store;
                        r_sticky <= w_ovf;
                        r_count  <= CNT_W'(1);
                    end
                    default: begin
                        r_sticky <= r_sticky | w_ovf;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_signed_accum_sat.sv
// Bench for signed_accum_sat: a default-width instance (N=8, ACC_W=12, CNT_W=8)
// and a narrow instance (N=8, ACC_W=8, CNT_W=2) driven by the same stimulus.

module tb_signed_accum_sat;

`ifdef SIGNED_ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstN;
    logic              in_valid;
    logic [1:0]        op;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic              out_ready;

    logic               in_ready0, out_valid0, ovf0, sticky0;
    logic signed [11:0] res0;
    logic [7:0]         cnt0;
    logic               in_ready1, out_valid1, ovf1, sticky1;
    logic signed [7:0]  res1;
    logic [1:0]         cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signed_accum_sat #(.N(8), .ACC_W(12), .CNT_W(8)) u_dut0 (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .result(res0), .ovf(ovf0), .ovf_sticky(sticky0), .count(cnt0)
    );

    signed_accum_sat #(.N(8), .ACC_W(8), .CNT_W(2)) u_dut1 (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(res1), .ovf(ovf1), .ovf_sticky(sticky1), .count(cnt1)
    );

    typedef struct {
        logic [1:0] op;
        int         a;
        int         b;
        int         r0;
        bit         o0;
        bit         s0;
        int         c0;
        int         r1;
        bit         o1;
        bit         s1;
        int         c1;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // op, a, b | dut0: res ovf sticky count | dut1: res ovf sticky count
        vt[0]  = '{2'b00,  100,   50,  150, 0, 0, 0, SAT ?  127 : -106, 1, 1, 0};
        vt[1]  = '{2'b01, -128,    1, -129, 0, 0, 0, SAT ? -128 :  127, 1, 1, 0};
        vt[2]  = '{2'b01, -128,  127, -255, 0, 0, 0, SAT ? -128 :    1, 1, 1, 0};
        vt[3]  = '{2'b00,  127,  127,  254, 0, 0, 0, SAT ?  127 :   -2, 1, 1, 0};
        vt[4]  = '{2'b00, -128, -128, -256, 0, 0, 0, SAT ? -128 :    0, 1, 1, 0};
        vt[5]  = '{2'b00,    3,   -5,   -2, 0, 0, 0,   -2, 0, 1, 0};
        vt[6]  = '{2'b01,   50,  -77,  127, 0, 0, 0,  127, 0, 1, 0};
        vt[7]  = '{2'b00, -100,  -28, -128, 0, 0, 0, -128, 0, 1, 0};
        vt[8]  = '{2'b11,   10,   99,   10, 0, 0, 1,   10, 0, 0, 1};
        vt[9]  = '{2'b10,   -3,   99,    7, 0, 0, 2,    7, 0, 0, 2};
        vt[10] = '{2'b10,   -3,   99,    4, 0, 0, 3,    4, 0, 0, 3};
        vt[11] = '{2'b10,   -3,   99,    1, 0, 0, 4,    1, 0, 0, 3};
        vt[12] = '{2'b10,   -3,   99,   -2, 0, 0, 5,   -2, 0, 0, 3};
        vt[13] = '{2'b10, -128,    0, -130, 0, 0, 6, SAT ? -128 :  126, 1, 1, 3};
        vt[14] = '{2'b00,    1,    1,    2, 0, 0, 6,    2, 0, 1, 3};
        vt[15] = '{2'b11,   -5,    0,   -5, 0, 0, 1,   -5, 0, 0, 1};
        vt[16] = '{2'b10,  127,    0,  122, 0, 0, 2,  122, 0, 0, 2};

        rstN      = 1'b0;
        in_valid  = 1'b1;
        op        = 2'b00;
        a         = 8'sd5;
        b         = 8'sd5;
        out_ready = 1'b1;

        // Reset held for two edges with in_valid asserted.
        step();
        step();
        chk("rst_out_valid", 32'(out_valid0), 0);
        chk("rst_result",    32'(res0), 0);
        chk("rst_count",     32'(cnt0), 0);
        chk("rst_sticky",    32'(sticky0), 0);
        chk("rst_in_ready",  32'(in_ready0), 1);
        rstN     = 1'b1;
        in_valid = 1'b0;
        step();
        chk("idle_out_valid", 32'(out_valid0), 0);
        chk("idle_in_ready",  32'(in_ready1), 1);

        // Back-to-back vectors with out_ready=1: one result per cycle, no bubbles.
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            op       = vt[i].op;
            a        = 8'(vt[i].a);
            b        = 8'(vt[i].b);
            step();
            chk($sformatf("v%0d_valid0", i),  32'(out_valid0), 1);
            chk($sformatf("v%0d_valid1", i),  32'(out_valid1), 1);
            chk($sformatf("v%0d_res0", i),    32'(res0), vt[i].r0);
            chk($sformatf("v%0d_ovf0", i),    32'(ovf0), 32'(vt[i].o0));
            chk($sformatf("v%0d_sticky0", i), 32'(sticky0), 32'(vt[i].s0));
            chk($sformatf("v%0d_cnt0", i),    32'(cnt0), vt[i].c0);
            chk($sformatf("v%0d_res1", i),    32'(res1), vt[i].r1);
            chk($sformatf("v%0d_ovf1", i),    32'(ovf1), 32'(vt[i].o1));
            chk($sformatf("v%0d_sticky1", i), 32'(sticky1), 32'(vt[i].s1));
            chk($sformatf("v%0d_cnt1", i),    32'(cnt1), vt[i].c1);
        end

        // Output transfer with no new input: valid drops, result is kept.
        in_valid = 1'b0;
        step();
        chk("drain_valid",  32'(out_valid0), 0);
        chk("drain_result", 32'(res0), 122);

        // Backpressure: first result stalls, second operand must wait.
        in_valid  = 1'b1;
        op        = 2'b00;
        a         = 8'sd5;
        b         = 8'sd6;
        out_ready = 1'b0;
        step();
        chk("bp_first_valid", 32'(out_valid0), 1);
        chk("bp_first_res",   32'(res0), 11);
        a = 8'sd20;
        b = 8'sd30;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready0), 0);
            step();
            chk($sformatf("bp_hold_res_%0d", k),   32'(res0), 11);
            chk($sformatf("bp_hold_valid_%0d", k), 32'(out_valid0), 1);
            chk($sformatf("bp_hold_cnt_%0d", k),   32'(cnt0), 2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready0), 1);
        step();
        chk("bp_second_res",   32'(res0), 50);
        chk("bp_second_valid", 32'(out_valid0), 1);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", 32'(out_valid0), 0);
        chk("bp_drain_res",   32'(res0), 50);

        // Reset in the middle of accumulation discards accumulator and count.
        in_valid = 1'b1;
        op       = 2'b11;
        a        = 8'sd7;
        step();
        op = 2'b10;
        a  = 8'sd1;
        step();
        chk("pre_rst_res", 32'(res0), 8);
        rstN = 1'b0;
        step();
        chk("mid_rst_valid", 32'(out_valid0), 0);
        chk("mid_rst_res",   32'(res0), 0);
        rstN = 1'b1;
        a    = 8'sd2;
        step();
        chk("post_rst_acc_res", 32'(res0), 2);
        chk("post_rst_acc_cnt", 32'(cnt0), 1);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_accum_sat.md
Name: signed_accum_sat

Overview:
- Parametrised successor to the team's plain signed adder.
- Registered signed arithmetic unit with ADD, SUB, ACCUMULATE and CLEAR/LOAD modes.
- Valid/ready handshake on both sides, accumulator headroom, overflow detection and optional saturation.
- Sits in datapaths as a streaming sum/difference/running-total stage between handshake-connected producers and consumers.

Parameters:
- N, 8, signed input operand width (N >= 2)
- ACC_W, 12, signed result/accumulator width (ACC_W >= N)
- CNT_W, 8, width of accumulated-sample counter

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  synchronous active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  unit can accept operands this cycle
- op  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- a  input  N  signed operand A
- b  input  N  signed operand B (ignored for ACC/CLR)
- out_valid  output  1  result register holds valid data
- out_ready  input  1  consumer accepts result
- result  output  ACC_W  signed result
- ovf  output  1  overflow occurred for the current result
- ovf_sticky  output  1  overflow seen since last CLR/reset
- count  output  CNT_W  samples in accumulator since last CLR

Behaviour:
- Reset is synchronous: when rstN=0 at a clk edge, then out_valid=0, result=0, ovf=0, ovf_sticky=0, count=0, accumulator=0. in_ready is combinational and equals 1 out of reset.
- Reset mid-operation discards any pending result and the accumulator contents.
- Handshake:
  - in_ready = !out_valid || out_ready. A single output register; no skid buffer.
  - An input transfer is in_valid && in_ready.
  - An output transfer is out_valid && out_ready.
  - Latency is 1 cycle: a result is visible the cycle after input transfer.
  - Full throughput: a simultaneous output transfer and input transfer replaces result in the same cycle.
  - While out_valid=1 && out_ready=0, result, ovf and count are held stable and in_ready=0.
  - Output transfer with no input transfer: out_valid clears next cycle; result keeps its value.
- Arithmetic: a and b are sign-extended to ACC_W+1 bits and the exact sum is formed at ACC_W+1 bits.
  - ADD: exact = a + b. Accumulator unchanged.
  - SUB: exact = a - b. Accumulator unchanged. Covers -128 - 127 at N=8.
  - ACC: exact = acc + a. The accumulator takes the ACC_W-bit stored result. count increments and saturates at 2^CNT_W-1 (no wrap).
  - CLR: exact = a. The accumulator loads a. count=1, ovf_sticky cleared before this op's ovf is applied (a load never overflows).
- Overflow: ovf=1 when exact lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Stored result is per the Optional Feature.
  - ovf_sticky |= ovf on every input transfer.
- ADD/SUB never alter the accumulator, count or ovf_sticky except via OR-ing ovf into ovf_sticky.
- No internal FSM beyond the output-valid state:
  - EMPTY (out_valid=0) -> FULL on input transfer.
  - FULL -> EMPTY on output transfer without input transfer.
  - FULL -> FULL on output transfer with input transfer, or when stalled.

Optional Feature:
- Macro SIGNED_ACCUM_SATURATE_EN.
- Defined: an overflowing result clamps to 2^(ACC_W-1)-1 when exact is positive, or -2^(ACC_W-1) when negative. The accumulator stores the clamped value. ovf is still asserted.
- Undefined: result wraps, i.e. the low ACC_W bits of exact. The accumulator stores the wrapped value. ovf is still asserted.
- Ports and timing are identical in both builds.

Test Plan:
- Reset/idle: rstN=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, count=0, in_ready=1 after reset.
- ADD/SUB, N=8, ACC_W=8:
  - ADD a=100, b=50 -> exact=150, ovf=1. Result 127 with SATURATE_EN, -106 without.
  - SUB a=-128, b=1 -> result -128 (sat) or 127 (wrap), ovf=1.
- Accumulate, defaults:
  - CLR a=10, then ACC a=-3 four times -> results 10, 7, 4, 1, -2.
  - count 1..5, ovf_sticky=0.
- Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0, result stable, second operand not consumed. out_ready=1 -> next result appears 1 cycle after acceptance.
- Throughput: in_valid=1 and out_ready=1 continuously, 8 ADDs -> 8 consecutive results with no bubbles.
- Counter saturation and sticky, CNT_W=2: CLR then 5 ACCs -> count saturates at 3. An overflowing ACC sets ovf_sticky, which persists across ADDs until the next CLR.
